// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: advances PC on fetch handshake, resolves
// JAL/JALR/branch targets, traps misaligned targets and keeps a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   INITPC     = '0,
    parameter logic [XLEN-1:0]   TRAP_VEC   = XLEN'(32'h100),
    parameter int unsigned       ALIGN_BITS = 2,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            iready,
    input  logic            stall,
    input  logic            op_valid,
    input  logic [1:0]      op_kind,
    input  logic [2:0]      br_cond,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] link,
    output logic            taken,
    output logic            trap,
    output logic [XLEN-1:0] bad_addr,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_BR   = 2'b11;

    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [XLEN-1:0]  bad_addr_reg, bad_addr_next;
    logic             trap_reg, trap_next;
    logic [PTR_W-1:0] top_reg, top_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0]  ras_mem_reg [RAS_DEPTH];

    logic             advance;
    logic             cond_ok;
    logic [XLEN-1:0]  target;
    logic             trap_fire;
    logic             ras_act;
    logic             ras_wr;
    logic [PTR_W-1:0] wr_ptr;

    assign advance = iready & ~stall;
    assign link    = pc_reg + XLEN'(4);

    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            3'b000:  cond_ok = zero;
            3'b001:  cond_ok = ~zero;
            3'b100:  cond_ok = lt;
            3'b101:  cond_ok = ~lt;
            3'b110:  cond_ok = ltu;
            3'b111:  cond_ok = ~ltu;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_reg + imm;
        if (op_kind == KIND_JALR) begin
            target = (rs1 + imm) & ~XLEN'(1);
        end
    end

    assign taken = op_valid & ((op_kind == KIND_JAL) | (op_kind == KIND_JALR) |
                               ((op_kind == KIND_BR) & cond_ok));
    assign trap_fire = taken & (|target[ALIGN_BITS-1:0]);

    always_comb begin
        pc_next       = pc_reg;
        bad_addr_next = bad_addr_reg;
        trap_next     = 1'b0;
        if (advance) begin
            if (trap_fire) begin
                pc_next       = TRAP_VEC;
                bad_addr_next = target;
                trap_next     = 1'b1;
            end else if (taken) begin
                pc_next = target;
            end else begin
                pc_next = link;
            end
        end
    end

    // A trapped transfer never reaches the RAS; push with pop on an empty stack acts as push.
    assign ras_act = advance & op_valid & ~trap_fire;

    always_comb begin
        top_next = top_reg;
        cnt_next = cnt_reg;
        ras_wr   = 1'b0;
        wr_ptr   = top_reg;
        if (ras_act) begin
            if (ras_push && (!ras_pop || cnt_reg == '0)) begin
                ras_wr   = 1'b1;
                wr_ptr   = top_reg + PTR_W'(1);
                top_next = top_reg + PTR_W'(1);
                cnt_next = (cnt_reg == RAS_FULL) ? cnt_reg : cnt_reg + CNT_W'(1);
            end else if (ras_push && ras_pop) begin
                ras_wr = 1'b1;
            end else if (ras_pop && cnt_reg != '0) begin
                top_next = top_reg - PTR_W'(1);
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pc_reg       <= INITPC;
            bad_addr_reg <= '0;
            trap_reg     <= 1'b0;
            top_reg      <= '0;
            cnt_reg      <= '0;
        end else begin
            pc_reg       <= pc_next;
            bad_addr_reg <= bad_addr_next;
            trap_reg     <= trap_next;
            top_reg      <= top_next;
            cnt_reg      <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clk) begin
                if (RST) begin
                    ras_mem_reg[gi] <= '0;
                end else if (ras_wr && wr_ptr == PTR_W'(gi)) begin
                    ras_mem_reg[gi] <= link;
                end
            end
        end
    endgenerate

    assign pc        = pc_reg;
    assign trap      = trap_reg;
    assign bad_addr  = bad_addr_reg;
    assign ras_valid = (cnt_reg != '0);
    assign ras_top   = ras_valid ? ras_mem_reg[top_reg] : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear stimulus, hand-computed expectations,
// immediate assertions at every comparison point.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        RST;
    logic        iready, stall, op_valid;
    logic [1:0]  op_kind;
    logic [2:0]  br_cond;
    logic        zero, lt, ltu;
    logic [31:0] rs1, imm;
    logic        ras_push, ras_pop;
    logic [31:0] pc, link, bad_addr, ras_top;
    logic        taken, trap, ras_valid;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer #(
        .XLEN(32), .INITPC(32'h0), .TRAP_VEC(32'h100), .ALIGN_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .RST(RST), .iready(iready), .stall(stall),
        .op_valid(op_valid), .op_kind(op_kind), .br_cond(br_cond),
        .zero(zero), .lt(lt), .ltu(ltu), .rs1(rs1), .imm(imm),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc), .link(link), .taken(taken), .trap(trap),
        .bad_addr(bad_addr), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_ops();
        op_valid = 1'b0; op_kind = 2'b00; br_cond = 3'b000;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        rs1 = '0; imm = '0; ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    task automatic set_op(input logic [1:0] kind, input logic [2:0] cond,
                          input logic [31:0] rs1_v, input logic [31:0] imm_v,
                          input logic push, input logic pop);
        op_valid = 1'b1; op_kind = kind; br_cond = cond;
        rs1 = rs1_v; imm = imm_v; ras_push = push; ras_pop = pop;
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("cycle: pc=%h trap=%b bad_addr=%h ras_top=%h ras_valid=%b",
                 pc, trap, bad_addr, ras_top, ras_valid);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; iready = 1'b1; stall = 1'b0;
        clr_ops();
        do_reset();

        // 1: reset values and free-running fetch
        check("rst_pc", pc, 32'h0);
        check("rst_trap", {31'b0, trap}, 32'h0);
        check("rst_ras_valid", {31'b0, ras_valid}, 32'h0);
        check("rst_ras_top", ras_top, 32'h0);
        check("rst_bad_addr", bad_addr, 32'h0);
        check("rst_link", link, 32'h4);
        step(); check("seq_pc4", pc, 32'h4);
        step(); check("seq_pc8", pc, 32'h8);
        step(); check("seq_pcC", pc, 32'hC);
        check("seq_trap", {31'b0, trap}, 32'h0);
        repeat (5) step();
        check("seq_pc20", pc, 32'h20);

        // 2: branches and condition decoding
        set_op(2'b11, 3'b100, 32'h0, 32'h10, 1'b0, 1'b0);
        #1 check("blt_taken", {31'b0, taken}, 32'h0);
        step(); check("blt_pc", pc, 32'h24);
        set_op(2'b11, 3'b101, 32'h0, 32'hC, 1'b0, 1'b0);
        #1 check("bge_taken", {31'b0, taken}, 32'h1);
        step(); check("bge_pc", pc, 32'h30);
        zero = 1'b1; ltu = 1'b1; lt = 1'b1;
        br_cond = 3'b000; #1 check("beq_taken", {31'b0, taken}, 32'h1);
        br_cond = 3'b001; #1 check("bne_taken", {31'b0, taken}, 32'h0);
        br_cond = 3'b110; #1 check("bltu_taken", {31'b0, taken}, 32'h1);
        br_cond = 3'b111; #1 check("bgeu_taken", {31'b0, taken}, 32'h0);
        br_cond = 3'b010; #1 check("rsv010_taken", {31'b0, taken}, 32'h0);
        br_cond = 3'b011; #1 check("rsv011_taken", {31'b0, taken}, 32'h0);
        op_kind = 2'b01; op_valid = 1'b0;
        #1 check("jal_novalid_taken", {31'b0, taken}, 32'h0);
        op_kind = 2'b00; op_valid = 1'b1;
        #1 check("kind0_taken", {31'b0, taken}, 32'h0);

        // 3: misaligned JALR traps; RAS untouched by trapped push
        clr_ops();
        set_op(2'b10, 3'b000, 32'h103, 32'h0, 1'b1, 1'b0);
        #1 check("jalr_mis_taken", {31'b0, taken}, 32'h1);
        step();
        check("trap_pc", pc, 32'h100);
        check("trap_pulse", {31'b0, trap}, 32'h1);
        check("trap_bad_addr", bad_addr, 32'h102);
        check("trap_ras_untouched", {31'b0, ras_valid}, 32'h0);
        clr_ops(); iready = 1'b0;
        step();
        check("trap_drop_noadv", {31'b0, trap}, 32'h0);
        check("noadv_pc_hold", pc, 32'h100);
        iready = 1'b1;
        set_op(2'b10, 3'b000, 32'h201, 32'h10, 1'b0, 1'b0);
        step();
        check("jalr_bit0_pc", pc, 32'h210);
        check("jalr_trap0", {31'b0, trap}, 32'h0);
        check("bad_addr_hold", bad_addr, 32'h102);

        // 4: stall freezes pc
        set_op(2'b01, 3'b000, 32'h0, 32'h40, 1'b0, 1'b0);
        stall = 1'b1;
        step(); check("stall_pc1", pc, 32'h210);
        step(); check("stall_pc2", pc, 32'h210);
        step(); check("stall_pc3", pc, 32'h210);
        stall = 1'b0;
        step(); check("release_pc", pc, 32'h250);

        // 5: RAS overflow wraps, pops in LIFO order
        clr_ops();
        do_reset();
        check("ras_rst_pc", pc, 32'h0);
        set_op(2'b01, 3'b000, 32'h0, 32'h4, 1'b1, 1'b0);
        repeat (5) step();
        check("push_pc", pc, 32'h14);
        check("push_top", ras_top, 32'h14);
        check("push_valid", {31'b0, ras_valid}, 32'h1);
        ras_push = 1'b0; ras_pop = 1'b1;
        check("pop0_top", ras_top, 32'h14); step();
        check("pop1_top", ras_top, 32'h10); step();
        check("pop2_top", ras_top, 32'hC);  step();
        check("pop3_top", ras_top, 32'h8);  step();
        check("pop_empty_valid", {31'b0, ras_valid}, 32'h0);
        check("pop_empty_top", ras_top, 32'h0);
        step();
        check("underflow_valid", {31'b0, ras_valid}, 32'h0);
        check("underflow_pc", pc, 32'h28);

        // 6: push&pop replaces top, then reset mid-trap and mid-stall
        clr_ops();
        do_reset();
        step();
        set_op(2'b01, 3'b000, 32'h0, 32'h4, 1'b1, 1'b0);
        step();
        check("one_entry_top", ras_top, 32'h8);
        clr_ops();
        repeat (18) step();
        check("pc50", pc, 32'h50);
        set_op(2'b01, 3'b000, 32'h0, 32'h4, 1'b1, 1'b1);
        step();
        check("pushpop_top", ras_top, 32'h54);
        check("pushpop_valid", {31'b0, ras_valid}, 32'h1);
        ras_push = 1'b0;
        step();
        check("pushpop_count1", {31'b0, ras_valid}, 32'h0);
        check("pc58", pc, 32'h58);
        ras_push = 1'b1; ras_pop = 1'b0;
        step();
        check("repush_valid", {31'b0, ras_valid}, 32'h1);
        set_op(2'b10, 3'b000, 32'h103, 32'h0, 1'b0, 1'b0);
        step();
        check("pre_rst_trap", {31'b0, trap}, 32'h1);
        RST = 1'b1; stall = 1'b1;
        set_op(2'b01, 3'b000, 32'h0, 32'h40, 1'b1, 1'b0);
        step();
        RST = 1'b0; stall = 1'b0;
        clr_ops();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_trap", {31'b0, trap}, 32'h0);
        check("mid_rst_bad_addr", bad_addr, 32'h0);
        check("mid_rst_ras_valid", {31'b0, ras_valid}, 32'h0);
        check("mid_rst_ras_top", ras_top, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
